// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and store back-pressure.
// Registers: 0x0 TXDATA (store), 0x4 STATUS (load), 0x8 DIVISOR (store/load).
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        clk_stall,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [15:0] divisor, baud, div_m1;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic empty, full, busy, bit_end, wr_tx, wr_div, push, pop;
  logic [31:0] rd_val;
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign busy = state != IDLE;
  assign bit_end = baud == '0;
  assign div_m1 = divisor - 16'd1;
  assign wr_tx = req_valid && req_write && req_addr == 4'h0;
  assign wr_div = req_valid && req_write && req_addr == 4'h8;
  // A full FIFO still accepts the store in the cycle the serialiser pops.
  assign clk_stall = wr_tx && full && !pop;
  assign push = wr_tx && !clk_stall;
  assign rd_val = req_addr == 4'h4 ? {24'b0, 4'(count), full, empty, busy, 1'b0}
                : req_addr == 4'h8 ? {16'b0, divisor} : 32'b0;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    unique case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      START: state_n = bit_end ? DATA : START;
      DATA: state_n = bit_end && bit_cnt == 3'd7 ? STOP : DATA;
      STOP: begin
        pop = bit_end && !empty;
        state_n = !bit_end ? STOP : empty ? IDLE : START;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= req_wdata[7:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      divisor <= DEFAULT_DIVISOR;
      baud <= '0;
      shift <= '0;
      bit_cnt <= '0;
      tx <= 1'b1;
      rdata <= '0;
      irq_empty <= 1'b1;
    end else begin
      state <= state_n;
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (wr_div) divisor <= req_wdata < 16'd2 ? 16'd2 : req_wdata;
      if (req_valid && !req_write) rdata <= rd_val;
      irq_empty <= empty && !busy;
      // Registered pin keeps tx glitch-free; it trails the state by one cycle.
      tx <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      if (pop) begin
        shift <= mem[rptr];
        bit_cnt <= '0;
        baud <= div_m1;
      end else if (busy) begin
        baud <= bit_end ? div_m1 : baud - 16'd1;
        if (state == DATA && bit_end) begin
          shift <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx with hand-computed frames and register values.
module tb_mmio_uart_tx;
  logic clk = 1'b0, rst_n = 1'b1, req_valid = 1'b0, req_write = 1'b0;
  logic [3:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic clk_stall, tx, irq_empty, ld_stall;
  logic [31:0] rdata, rd, rd_b;
  int n_tests = 0, n_fail = 0, st, st_sum, w;

  mmio_uart_tx #(.FIFO_DEPTH(4), .DEFAULT_DIVISOR(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .clk_stall(clk_stall),
    .rdata(rdata), .tx(tx), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [3:0] a, input logic [15:0] d, output int stalls);
    stalls = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (clk_stall === 1'b1 && stalls < 500) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls == 500) check("stall_timeout", stalls, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, output logic [31:0] d);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(negedge clk);
    ld_stall = clk_stall;
    @(posedge clk); #1;
    req_valid = 1'b0;
    d = rdata;
  endtask

  task automatic expect_tx(input string tag, input logic v, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== v) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input int d0, input int d);
    int bad, n;
    logic e;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      e = i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
      n = i == 0 ? d0 : d;
      repeat (n) begin
        @(negedge clk);
        if (tx !== e) bad++;
      end
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_irq", irq_empty, 1);
    check("rst_stall", clk_stall, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(4'h8, rd); check("rst_div", rd, 32'h10);
    load(4'h4, rd); check("rst_status", rd, 32'h04);

    store(4'h0, 16'h0041, st);
    expect_tx("single_pre", 1'b1, 2);
    check("single_irq_busy", irq_empty, 0);
    check_frame("single_frame", 8'h41, 16, 16);
    @(negedge clk);
    check("single_irq_done", irq_empty, 1);
    @(posedge clk); #1;

    store(4'h8, 16'd4, st);
    store(4'h0, 16'h0055, st);
    store(4'h0, 16'h00AA, st);
    store(4'h0, 16'h00FF, st);
    fork
      begin
        check_frame("b2b_f0", 8'h55, 4, 4);
        check_frame("b2b_f1", 8'hAA, 4, 4);
        check_frame("b2b_f2", 8'hFF, 4, 4);
      end
      begin
        load(4'h4, rd_b); check("b2b_cnt2", rd_b, 32'h22);
        repeat (39) @(posedge clk); #1;
        load(4'h4, rd_b); check("b2b_cnt1", rd_b, 32'h12);
        repeat (39) @(posedge clk); #1;
        load(4'h4, rd_b); check("b2b_cnt0", rd_b, 32'h06);
      end
    join
    @(negedge clk);
    check("b2b_irq", irq_empty, 1);
    @(posedge clk); #1;

    store(4'h0, 16'h0001, st);
    st_sum = 0;
    for (int i = 0; i < 4; i++) begin
      store(4'h0, 16'h0010 + 16'(i), st);
      st_sum += st;
    end
    check("full_fill_nostall", st_sum, 0);
    store(4'h0, 16'h0020, st);
    check("full_stall_cycles", st, 36);
    load(4'h4, rd);
    check("full_ld_nostall", ld_stall, 0);
    check("full_status", rd, 32'h4A);
    w = 0;
    while (irq_empty !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("full_drain", irq_empty, 1);
    @(posedge clk); #1;

    store(4'h8, 16'd16, st);
    store(4'h0, 16'h00C3, st);
    fork
      begin
        expect_tx("div_pre", 1'b1, 2);
        check_frame("div_frame", 8'hC3, 16, 8);
      end
      begin
        repeat (4) @(posedge clk); #1;
        store(4'h8, 16'd8, st);
      end
    join
    @(posedge clk); #1;
    load(4'h8, rd); check("div_rd8", rd, 32'h8);
    store(4'h8, 16'd0, st);
    load(4'h8, rd); check("div_clamp", rd, 32'h2);

    store(4'hC, 16'h1234, st);
    check("unmap_nostall", st, 0);
    load(4'h8, rd); check("unmap_div", rd, 32'h2);
    load(4'hC, rd); check("unmap_rd", rd, 32'h0);
    load(4'h8, rd);
    load(4'h0, rd); check("txdata_rd", rd, 32'h0);
    load(4'h4, rd); check("unmap_status", rd, 32'h04);

    store(4'h0, 16'h0011, st);
    store(4'h0, 16'h0022, st);
    store(4'h0, 16'h0033, st);
    @(negedge clk);
    check("mid_tx_low", tx, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_irq", irq_empty, 1);
    check("mid_rst_stall", clk_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_tx("mid_rst_idle", 1'b1, 30);
    @(posedge clk); #1;
    load(4'h4, rd); check("mid_rst_status", rd, 32'h04);
    load(4'h8, rd); check("mid_rst_div", rd, 32'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped I/O responder on the processor's load/store path. The processor's ram block is the initiator; this block is the responder.
- It accepts byte stores to a TX data register and buffers them in a small FIFO.
- It serialises buffered bytes as 8N1 UART frames on a single output pin.
- It asserts a stall back to the processor when a store cannot be accepted, using the same mechanism as clk_stall.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- DEFAULT_DIVISOR, 16, clk cycles per UART bit after reset; 16-bit value.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  MMIO access this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  4  byte offset: 0x0 TXDATA, 0x4 STATUS, 0x8 DIVISOR
- req_wdata  input  16  store data; TXDATA uses [7:0], DIVISOR uses [15:0]
- clk_stall  output  1  combinational; 1 = processor must hold the request
- rdata  output  32  load result, registered
- tx  output  1  UART serial line; idles high
- irq_empty  output  1  1 when the FIFO is empty and the serialiser is idle

Behaviour:
- Reset (async, rst_n=0) sets:
  - FIFO empty, read/write pointers 0, count 0
  - divisor = DEFAULT_DIVISOR
  - FSM in IDLE, tx=1, rdata=0, irq_empty=1, clk_stall=0
- Reset mid-frame aborts the frame immediately: tx=1, queued bytes discarded.
- Access rules:
  - Store to TXDATA with FIFO not full: push req_wdata[7:0] on this posedge; clk_stall=0.
  - Store to TXDATA with FIFO full: clk_stall=1 combinationally; no push. The processor holds the request. The push completes on the first cycle a slot is free, in the same cycle the stall drops.
  - Store to DIVISOR: divisor <= req_wdata[15:0]. A value below 2 is clamped to 2. The new value takes effect at the next bit boundary, not mid-bit.
  - Store to STATUS or an unmapped offset: ignored, no stall.
  - Load: rdata updates on the posedge after req_valid and is valid one cycle later. Values by offset:
    - STATUS: {24'b0, count[3:0], fifo_full, fifo_empty, busy, 1'b0}
    - DIVISOR: {16'b0, divisor}
    - TXDATA and unmapped offsets: 0
  - Loads never stall.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - count ranges 0..FIFO_DEPTH; full when count==FIFO_DEPTH, empty when count==0.
  - Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full, so a stall drops in the same cycle the serialiser pops.
- Serialiser FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If the FIFO is not empty, pop into a shift register, load the bit counter with 0, load the baud counter with divisor-1, go to START.
  - START: tx=0 for divisor cycles.
  - DATA: tx = shift[0], LSB first. Each bit lasts divisor cycles. After bit 7, go to STOP.
  - STOP: tx=1 for divisor cycles. Then, if the FIFO is not empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
  - busy=1 in every state except IDLE.
- Frame timing: exactly 10*divisor cycles from the first START cycle to the end of STOP.
- Latency: a push into an empty FIFO while IDLE gives tx=0 starting 2 cycles after the push posedge (1 cycle for the FIFO write, 1 cycle for the IDLE pop).
- irq_empty = fifo_empty && !busy, registered.

Test Plan:
- Reset check: rst_n low mid-frame → tx=1, STATUS reads 0x00000004 (empty), divisor reads 16, clk_stall=0.
- Single byte: store 0x41 to TXDATA, divisor 16:
  - tx low at push+2 cycles, for 16 cycles
  - then bits 1,0,0,0,0,0,1,0 at 16 cycles each
  - stop high for 16 cycles
  - irq_empty rises after the frame
- Back-to-back frames: 3 stores 0x55, 0xAA, 0xFF with divisor 4 → 3 frames of 40 cycles each with no idle gap; STATUS count decrements 2,1,0.
- Full FIFO: 5 consecutive stores with FIFO_DEPTH=4 while busy → the 5th store sees clk_stall=1 until the first STOP completes; the pop and push coincide and count stays 4.
- Divisor change: store 8 to DIVISOR mid-bit → the current bit finishes at the old width, the next bit is 8 cycles. Store 0 → reads back 2.
- Unmapped and readback: store to 0xC is ignored; load from 0xC returns 0; loads of STATUS while full return fifo_full=1 (bit 3) with no stall.
